uart_rx_ctrl: RTL and testbench

Receive-side controller for the UART sampler. It generates the sampler's mid-bit `tick` schedule from the sampler's `align` pulse, assembles the sampler's serial bit pulses into bytes, and classifies each frame as good, framing error or start glitch. Good bytes are buffered in a small FIFO with a valid/ready output. It sits between the sampler instance and the byte consumer in the receive path.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_byte_fifo.sv | 85 ++++++++
 rtl/uart_rx_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared constants, types and helpers for the UART receive path.
//            Provides the baud divider / half-bit computations, the frame
//            length in sample ticks, the tick FSM encoding and a saturating
//            increment for the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Sample ticks per frame: start bit, 8 data bits, stop bit.
    localparam int FRAME_TICKS = 10;

    // Width of the statistics counters.
    localparam int CNT_W = 8;

    // Width of one received data byte.
    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        TICK_IDLE = 1'b0,
        TICK_RUN  = 1'b1
    } tick_state_t;

    // Clock cycles per bit period.
    function automatic int calc_div(input int clk_freq_hz, input int baud_rate);
        return clk_freq_hz / baud_rate;
    endfunction

    // Offset from the start edge to the middle of the start bit (floor).
    function automatic int calc_half(input int div);
        return div / 2;
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_fifo
// Purpose  : Small synchronous FIFO for received bytes. Registered storage,
//            combinational head read, occupancy counter 0..DEPTH.
// Ports    : clk, rst_n (async, active-low), clear (sync flush)
//            push / push_data : write request and data
//            pop              : read request (ignored while empty)
//            full / empty     : status flags
//            level            : current occupancy
//            head             : oldest entry, 0 while empty
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         head
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              LVL_W    = AW + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign full  = (r_level == LVL_FULL);
    assign empty = (r_level == '0);

    // A pop on an empty FIFO is void; a push into a full FIFO only lands when
    // the same cycle frees the head slot.
    assign w_do_pop  = pop && !empty && !clear;
    assign w_do_push = push && (!full || w_do_pop) && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Forcing zero while empty keeps the head defined after reset or flush
    // without needing a reset on the storage array.
    assign head  = empty ? '0 : r_mem[r_rd_ptr];
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Purpose  : Receive-side controller for the UART sampler. Schedules the
//            mid-bit sample ticks, assembles sampled bits into bytes,
//            classifies frames and buffers good bytes in a FIFO.
// Ports    : clk, rst_n (async, active-low), clear (sync flush)
//            s_align, s_bit_valid, s_bit_data, s_framing_error,
//            s_frame_done, s_busy  : sampler status inputs
//            tick                  : registered sample strobe to sampler
//            out_valid/out_ready/out_data : byte stream to the consumer
//            level                 : FIFO occupancy
//            frame_err_cnt, glitch_cnt, overrun_cnt : saturating statistics
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 1_600_000,
    parameter int BAUD_RATE   = 100_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         s_align,
    input  logic                         s_bit_valid,
    input  logic                         s_bit_data,
    input  logic                         s_framing_error,
    input  logic                         s_frame_done,
    input  logic                         s_busy,
    output logic                         tick,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BYTE_W-1:0]            out_data,
    output logic [$clog2(FIFO_DEPTH):0]  level,
    output logic [CNT_W-1:0]             frame_err_cnt,
    output logic [CNT_W-1:0]             glitch_cnt,
    output logic [CNT_W-1:0]             overrun_cnt
);

    localparam int               DIV       = calc_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int               HALF      = calc_half(DIV);
    localparam int               PH_W      = $clog2(DIV + 1);
    // The phase counter fires when it reaches 1 and the tick is registered,
    // so loading HALF-1 puts the first tick exactly HALF cycles after align.
    localparam logic [PH_W-1:0]  PH_FIRST  = PH_W'(HALF - 1);
    localparam logic [PH_W-1:0]  PH_RELOAD = PH_W'(DIV);
    localparam logic [PH_W-1:0]  PH_FIRE   = PH_W'(1);
    localparam logic [3:0]       LAST_TICK = 4'(FRAME_TICKS - 1);
    localparam logic [3:0]       FULL_BYTE = 4'(BYTE_W);

    // ------------------------------------------------------------------
    // Tick scheduler
    // ------------------------------------------------------------------
    tick_state_t     r_state;
    tick_state_t     w_state_nxt;
    logic [PH_W-1:0] r_phase;
    logic [PH_W-1:0] w_phase_nxt;
    logic [3:0]      r_tick_cnt;
    logic [3:0]      w_tick_cnt_nxt;
    logic            r_tick;
    logic            w_tick_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= TICK_IDLE;
            r_phase    <= '0;
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_tick     <= w_tick_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_phase_nxt    = r_phase;
        w_tick_cnt_nxt = r_tick_cnt;
        w_tick_nxt     = 1'b0;
        if (clear) begin
            w_state_nxt    = TICK_IDLE;
            w_phase_nxt    = '0;
            w_tick_cnt_nxt = '0;
        end else begin
            case (r_state)
                TICK_IDLE: begin
                    if (s_align) begin
                        w_state_nxt    = TICK_RUN;
                        w_phase_nxt    = PH_FIRST;
                        w_tick_cnt_nxt = '0;
                    end
                end
                TICK_RUN: begin
                    if (r_phase == PH_FIRE) begin
                        w_tick_nxt     = 1'b1;
                        w_phase_nxt    = PH_RELOAD;
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                        if (r_tick_cnt == LAST_TICK) begin
                            w_state_nxt = TICK_IDLE;
                        end
                    end else if (!s_busy && !r_tick) begin
                        // Sampler gave up (start bit sampled high): stop.
                        w_state_nxt = TICK_IDLE;
                        w_phase_nxt = '0;
                    end else begin
                        w_phase_nxt = r_phase - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = TICK_IDLE;
                end
            endcase
        end
    end

    assign tick = r_tick;

    // ------------------------------------------------------------------
    // Byte assembler (LSB first)
    // ------------------------------------------------------------------
    logic [BYTE_W-1:0] r_shreg;
    logic [3:0]        r_bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (clear || s_align) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
        end else if (s_bit_valid) begin
            r_shreg <= {s_bit_data, r_shreg[BYTE_W-1:1]};
            // Saturate so a runaway bit stream can never wrap back to 8.
            if (r_bit_cnt != 4'hF) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame classification and FIFO
    // ------------------------------------------------------------------
    logic w_good;
    logic w_bad;
    logic w_glitch;
    logic w_overrun;
    logic w_pop;
    logic w_full;
    logic w_empty;
    logic r_ferr_d;

    assign w_good    = s_frame_done && !s_framing_error && (r_bit_cnt == FULL_BYTE);
    assign w_bad     = s_frame_done && !w_good;
    assign w_glitch  = s_framing_error && !r_ferr_d && !s_frame_done;
    assign w_pop     = out_valid && out_ready;
    assign w_overrun = w_good && w_full && !w_pop;
    assign out_valid = !w_empty;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (w_good),
        .push_data (r_shreg),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .level     (level),
        .head      (out_data)
    );

    logic [CNT_W-1:0] r_ferr_cnt;
    logic [CNT_W-1:0] r_glitch_cnt;
    logic [CNT_W-1:0] r_ovr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ferr_d     <= 1'b0;
            r_ferr_cnt   <= '0;
            r_glitch_cnt <= '0;
            r_ovr_cnt    <= '0;
        end else if (clear) begin
            r_ferr_d     <= 1'b0;
            r_ferr_cnt   <= '0;
            r_glitch_cnt <= '0;
            r_ovr_cnt    <= '0;
        end else begin
            r_ferr_d <= s_framing_error;
            if (w_bad) begin
                r_ferr_cnt <= sat_inc(r_ferr_cnt);
            end
            if (w_glitch) begin
                r_glitch_cnt <= sat_inc(r_glitch_cnt);
            end
            if (w_overrun) begin
                r_ovr_cnt <= sat_inc(r_ovr_cnt);
            end
        end
    end

    assign frame_err_cnt = r_ferr_cnt;
    assign glitch_cnt    = r_glitch_cnt;
    assign overrun_cnt   = r_ovr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Purpose  : Self-checking bench for uart_rx_ctrl. The bench plays the role
//            of the sampler: it issues align, answers each tick with the
//            matching bit strobe / frame-done pulse, and keeps a scoreboard
//            of bytes expected from the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int CLK_FREQ_HZ = 1_600_000;
    localparam int BAUD_RATE   = 100_000;
    localparam int FIFO_DEPTH  = 4;
    localparam int DIV         = 16;
    localparam int HALF        = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       s_align;
    logic       s_bit_valid;
    logic       s_bit_data;
    logic       s_framing_error;
    logic       s_frame_done;
    logic       s_busy;
    logic       tick;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] level;
    logic [7:0] frame_err_cnt;
    logic [7:0] glitch_cnt;
    logic [7:0] overrun_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        bit         glitch;
        int         nbits;
        bit         rdy_done;
        bit         accept;
        bit         drain_after;
        int         exp_level;
        int         exp_ferr;
        int         exp_glitch;
        int         exp_ovr;
        int         exp_ticks;
    } vec_t;

    vec_t vecs[14];

    uart_rx_ctrl #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD_RATE   (BAUD_RATE),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (clear),
        .s_align         (s_align),
        .s_bit_valid     (s_bit_valid),
        .s_bit_data      (s_bit_data),
        .s_framing_error (s_framing_error),
        .s_frame_done    (s_frame_done),
        .s_busy          (s_busy),
        .tick            (tick),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .level           (level),
        .frame_err_cnt   (frame_err_cnt),
        .glitch_cnt      (glitch_cnt),
        .overrun_cnt     (overrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [7:0] data, input bit stop_ok, input bit glitch,
                                input int nbits, input bit rdy, input bit accept, input bit drain,
                                input int lvl, input int ferr, input int gl, input int ovr,
                                input int ticks);
        vec_t v;
        v.data        = data;
        v.stop_ok     = stop_ok;
        v.glitch      = glitch;
        v.nbits       = nbits;
        v.rdy_done    = rdy;
        v.accept      = accept;
        v.drain_after = drain;
        v.exp_level   = lvl;
        v.exp_ferr    = ferr;
        v.exp_glitch  = gl;
        v.exp_ovr     = ovr;
        v.exp_ticks   = ticks;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare the current head against the oldest scoreboard entry.
    task automatic pop_check(input string name);
        logic [7:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: got byte %0h, expected none (scoreboard empty)", name, out_data);
        end else begin
            e = exp_q.pop_front();
            if (out_data !== e) begin
                bad++;
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, out_data, e, cyc);
            end
        end
    endtask

    task automatic count_ticks(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (tick) n++;
        end
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 4 * FIFO_DEPTH) begin
            check({name, "_valid"}, 32'(out_valid), 32'd1);
            pop_check(name);
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        check({name, "_level"}, 32'(level), 32'd0);
        check({name, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    // One frame through the sampler handshake, with per-frame checks.
    task automatic send_frame(input vec_t v, input string name);
        int  a_cyc;
        int  ntick;
        int  idx;
        bit  timing_ok;
        @(negedge clk);
        s_align = 1'b1;
        s_busy  = 1'b1;
        a_cyc   = cyc;
        @(negedge clk);
        s_align   = 1'b0;
        ntick     = 0;
        timing_ok = 1'b1;
        while ((cyc - a_cyc) < HALF + 12 * DIV) begin
            if (tick) begin
                if ((cyc - a_cyc) != HALF + ntick * DIV) timing_ok = 1'b0;
                idx = ntick;
                ntick++;
                @(negedge clk);
                if (idx == 0 && v.glitch) begin
                    s_framing_error = 1'b1;
                    s_busy          = 1'b0;
                end else if (idx >= 1 && idx <= 8) begin
                    if (idx <= v.nbits) begin
                        s_bit_valid = 1'b1;
                        s_bit_data  = v.data[idx-1];
                    end
                end else if (idx == 9) begin
                    s_frame_done    = 1'b1;
                    s_framing_error = !v.stop_ok;
                    out_ready       = v.rdy_done;
                    if (v.rdy_done && exp_q.size() > 0) pop_check({name, "_pop_at_done"});
                    if (v.accept) exp_q.push_back(v.data);
                end
                @(negedge clk);
                if (idx == 9) begin
                    check({name, "_level"}, 32'(level), 32'(v.exp_level));
                    check({name, "_valid"}, 32'(out_valid), 32'(v.exp_level > 0));
                    if (v.accept && v.exp_level == 1)
                        check({name, "_data"}, 32'(out_data), 32'(v.data));
                    s_busy = 1'b0;
                end
                s_bit_valid     = 1'b0;
                s_frame_done    = 1'b0;
                s_framing_error = 1'b0;
                out_ready       = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        s_busy = 1'b0;
        check({name, "_ticks"}, 32'(ntick), 32'(v.exp_ticks));
        check({name, "_tick_times"}, 32'(timing_ok), 32'd1);
        check({name, "_ferr_cnt"}, 32'(frame_err_cnt), 32'(v.exp_ferr));
        check({name, "_glitch_cnt"}, 32'(glitch_cnt), 32'(v.exp_glitch));
        check({name, "_ovr_cnt"}, 32'(overrun_cnt), 32'(v.exp_ovr));
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_tick"}, 32'(tick), 32'd0);
        check({name, "_valid"}, 32'(out_valid), 32'd0);
        check({name, "_data"}, 32'(out_data), 32'h00);
        check({name, "_level"}, 32'(level), 32'd0);
        check({name, "_ferr"}, 32'(frame_err_cnt), 32'd0);
        check({name, "_glitch"}, 32'(glitch_cnt), 32'd0);
        check({name, "_ovr"}, 32'(overrun_cnt), 32'd0);
    endtask

    initial begin
        int n;
        int a;

        //              data   stop gl nb rdy acc drn lvl fe gl ov tk
        vecs[0]  = mk(8'hA5, 1, 0, 8, 0, 1, 1, 1, 0, 0, 0, 10);
        vecs[1]  = mk(8'h3C, 0, 0, 8, 0, 0, 0, 0, 1, 0, 0, 10);
        vecs[2]  = mk(8'h00, 1, 1, 8, 0, 0, 0, 0, 1, 1, 0, 1);
        vecs[3]  = mk(8'h5A, 1, 0, 7, 0, 0, 0, 0, 2, 1, 0, 10);
        vecs[4]  = mk(8'h01, 1, 0, 8, 0, 1, 0, 1, 2, 1, 0, 10);
        vecs[5]  = mk(8'h02, 1, 0, 8, 0, 1, 0, 2, 2, 1, 0, 10);
        vecs[6]  = mk(8'h03, 1, 0, 8, 0, 1, 0, 3, 2, 1, 0, 10);
        vecs[7]  = mk(8'h04, 1, 0, 8, 0, 1, 0, 4, 2, 1, 0, 10);
        vecs[8]  = mk(8'h05, 1, 0, 8, 0, 0, 1, 4, 2, 1, 1, 10);
        vecs[9]  = mk(8'h10, 1, 0, 8, 0, 1, 0, 1, 2, 1, 1, 10);
        vecs[10] = mk(8'h11, 1, 0, 8, 0, 1, 0, 2, 2, 1, 1, 10);
        vecs[11] = mk(8'h12, 1, 0, 8, 0, 1, 0, 3, 2, 1, 1, 10);
        vecs[12] = mk(8'h13, 1, 0, 8, 0, 1, 0, 4, 2, 1, 1, 10);
        vecs[13] = mk(8'h77, 1, 0, 8, 1, 1, 1, 4, 2, 1, 1, 10);

        rst_n           = 1'b0;
        clear           = 1'b0;
        s_align         = 1'b0;
        s_bit_valid     = 1'b0;
        s_bit_data      = 1'b0;
        s_framing_error = 1'b0;
        s_frame_done    = 1'b0;
        s_busy          = 1'b0;
        out_ready       = 1'b0;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            send_frame(vecs[i], $sformatf("vec%0d", i));
            if (vecs[i].drain_after) drain($sformatf("drain%0d", i));
        end

        // Asynchronous reset in the middle of a frame, one byte queued.
        send_frame(mk(8'h42, 1, 0, 8, 0, 1, 0, 1, 2, 1, 1, 10), "pre_rst");
        @(negedge clk);
        s_align = 1'b1;
        s_busy  = 1'b1;
        a       = cyc;
        n       = 0;
        @(negedge clk);
        s_align = 1'b0;
        while (n < 5 && (cyc - a) < 12 * DIV) begin
            @(negedge clk);
            if (tick) n++;
        end
        check("ticks_before_reset", 32'(n), 32'd5);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        exp_q.delete();
        s_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        count_ticks(3 * DIV, n);
        check("ticks_after_reset", 32'(n), 32'd0);

        // Clear with three bytes queued and a frame in progress.
        send_frame(mk(8'h3C, 0, 0, 8, 0, 0, 0, 0, 1, 0, 0, 10), "pre_clr_bad");
        send_frame(mk(8'h21, 1, 0, 8, 0, 1, 0, 1, 1, 0, 0, 10), "pre_clr1");
        send_frame(mk(8'h22, 1, 0, 8, 0, 1, 0, 2, 1, 0, 0, 10), "pre_clr2");
        send_frame(mk(8'h23, 1, 0, 8, 0, 1, 0, 3, 1, 0, 0, 10), "pre_clr3");
        @(negedge clk);
        s_align = 1'b1;
        s_busy  = 1'b1;
        a       = cyc;
        n       = 0;
        @(negedge clk);
        s_align = 1'b0;
        while (n < 2 && (cyc - a) < 12 * DIV) begin
            @(negedge clk);
            if (tick) n++;
        end
        check("ticks_before_clear", 32'(n), 32'd2);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_idle_outputs("after_clear");
        exp_q.delete();
        count_ticks(3 * DIV, n);
        check("ticks_after_clear", 32'(n), 32'd0);
        s_busy = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
